fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the WISC 16-bit processor. It replaces the bare PC register and always-enabled instruction-memory read with a fetch FSM and a handshaked instruction memory interface that tolerates variable latency. Fetched words are buffered in a DEPTH-entry queue and delivered to decode over valid/ready. The block also handles branch redirect with queue flush and in-flight discard, and HLT detection with halt-after-drain.

## Interface
- ADDR_W, 16, PC/address width
- INST_W, 16, instruction width; opcode = inst[INST_W-1 -: 4]
- DEPTH, 2, instruction queue entries (power of 2, ≥2)
- RESET_PC, 0, fetch address after reset
- PC_STEP, 2, byte increment per sequential fetch
- clk  in  1  single clock, all state on posedge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request; once raised, held until completion
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1
- imem_rvalid  in  1  response strobe; completion = imem_req & imem_rvalid
- imem_rdata  in  INST_W  instruction word, valid on completion
- redirect  in  1  branch taken / BR / flush request
- redirect_pc  in  ADDR_W  new fetch address, sampled when redirect=1
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts head
- inst_data  out  INST_W  head instruction
- inst_pc  out  ADDR_W  address of head instruction
- pc  out  ADDR_W  current fetch PC (address of next/in-flight request)
- halted  out  1  sticky: HLT instruction has been accepted by decode

## Operation
- FSM states:
  - FETCH: imem_req = (count < DEPTH).
  - DRAIN: imem_req=1 at the old address; the response will be discarded.
  - HALT: imem_req=0.
  - STOPPED: imem_req=0, halted=1.
- FETCH completion: enqueue {rdata, addr}; pc += PC_STEP, wrapping mod 2^ADDR_W.
  - If the completed word's opcode is 4'hF, go to HALT with pc frozen.
- Dequeue occurs on inst_valid & inst_ready. Enqueue and dequeue in the same cycle leave count unchanged; with count==DEPTH this allows a new request next cycle.
- Redirect handling (priority over everything except rst):
  - Flush the queue (count=0) and set pc=redirect_pc.
  - If a request is outstanding and not completing this cycle, go to DRAIN and keep the old addr until completion, then drop the data and move to FETCH.
  - If completing this cycle, drop the data and go straight to FETCH.
  - From HALT, redirect returns to FETCH (the HLT was speculative).
- Redirect and dequeue in the same cycle: the dequeue is honoured; the flush applies to all remaining entries.
- Dequeue of an HLT word sets halted=1 next cycle and enters STOPPED. STOPPED ignores redirect and leaves only on rst.
- Empty queue: inst_valid=0; inst_data/inst_pc hold their last values.

## Timing
- Reset values, in force during and the cycle after rst: imem_req=0, imem_addr=pc=RESET_PC, inst_valid=0, count=0, halted=0, state FETCH.
- First imem_req=1 in the first cycle after rst falls.
- Zero-wait memory (rvalid tied 1): one fetch per cycle, PCs RESET_PC, +2, +4, …
- Fetch-to-inst_valid latency: 1 cycle after completion (registered queue).
- Redirect-to-new imem_addr: next cycle, or the cycle after DRAIN completion.
- rst mid-operation (including DRAIN) aborts immediately; the memory must tolerate the dropped request.

## Configuration
- FETCH_BYPASS_EN defined:
  - A completion into an empty queue with no redirect drives inst_valid/inst_data/inst_pc combinationally in the same cycle, giving 0-cycle latency.
  - If inst_ready=1 that cycle, the word is not written into the queue.
- FETCH_BYPASS_EN undefined: all words pass through the registered queue, giving 1-cycle latency.

## Test plan
- Reset, rvalid=1, ready=1, program ADD,SUB,HLT at 0x0000 -> inst_pc 0,2,4 on consecutive cycles; halted=1 the cycle after 0x0004 is accepted; imem_req stays 0 afterwards.
- ready=0, DEPTH=2, rvalid=1 -> exactly 2 completions (0x0000, 0x0002), then imem_req=0; ready=1 for one cycle -> one new request at 0x0004.
- rvalid delayed 3 cycles -> imem_req and imem_addr=0x0000 held stable for 3 cycles; word enqueued on the 4th.
- Redirect to 0x0040 while a request to 0x0006 waits 2 cycles -> imem_addr stays 0x0006 until completion, its data is never presented, next request is 0x0040, and queue entries are flushed.
- HLT fetched at 0x0008, then redirect to 0x0020 before decode accepts it -> halted stays 0 and fetch resumes at 0x0020.
- rst asserted during DRAIN -> next cycle imem_req=0, pc=RESET_PC, inst_valid=0, halted=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/response, redirect input,
// decode-side valid/ready output and status (pc, halted).
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned INST_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc, pc, halted,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, pc, halted,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// WISC instruction-fetch front end: fetch FSM with variable-latency imem
// handshake, DEPTH-entry instruction queue, redirect flush/drain and HLT stop.
// Optional FETCH_BYPASS_EN: a completion into an empty queue is presented to
// decode in the same cycle.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INST_W   = 16,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 2
) (
  input logic          i_clk,
  input logic          i_rst,
  fetch_unit_if.master io_bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StFetch, StDrain, StHalt, StStopped} state_e;

  function automatic logic is_hlt(input logic [INST_W-1:0] inst);
    return inst[INST_W-1 -: 4] == 4'hF;
  endfunction

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_pc, w_pc_d, r_drain_addr, w_drain_addr_d;
  logic [CNT_W-1:0]  r_count, w_count_d;
  logic [PTR_W-1:0]  r_wr_ptr, w_wr_ptr_d, r_rd_ptr, w_rd_ptr_d;
  logic              r_halted, w_halted_d;
  logic [INST_W-1:0] r_q_data [DEPTH];
  logic [ADDR_W-1:0] r_q_pc   [DEPTH];
  logic [INST_W-1:0] r_hold_data;
  logic [ADDR_W-1:0] r_hold_pc;

  logic              w_req, w_done, w_bypass, w_empty, w_valid, w_deq, w_enq;
  logic [ADDR_W-1:0] w_addr, w_head_pc;
  logic [INST_W-1:0] w_head_data;

  // Request, completion and queue-head selection.
  always_comb begin
    w_empty = (r_count == '0);
    w_addr  = (r_state == StDrain) ? r_drain_addr : r_pc;
    case (r_state)
      StFetch: w_req = (r_count < CNT_W'(DEPTH));
      StDrain: w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
    // Reset drops any request immediately; memory tolerates the abort.
    w_req  = w_req & ~i_rst;
    w_done = w_req & io_bus.imem_rvalid;
`ifdef FETCH_BYPASS_EN
    w_bypass = w_done & w_empty & ~io_bus.redirect & (r_state == StFetch);
`else
    w_bypass = 1'b0;
`endif
    w_valid = (~w_empty | w_bypass) & ~i_rst;
    if (!w_empty) begin
      w_head_data = r_q_data[r_rd_ptr];
      w_head_pc   = r_q_pc[r_rd_ptr];
    end else if (w_bypass) begin
      w_head_data = io_bus.imem_rdata;
      w_head_pc   = r_pc;
    end else begin
      w_head_data = r_hold_data;
      w_head_pc   = r_hold_pc;
    end
    w_deq = w_valid & io_bus.inst_ready;
  end

  assign io_bus.imem_req   = w_req;
  assign io_bus.imem_addr  = w_addr;
  assign io_bus.inst_valid = w_valid;
  assign io_bus.inst_data  = w_head_data;
  assign io_bus.inst_pc    = w_head_pc;
  assign io_bus.pc         = r_pc;
  assign io_bus.halted     = r_halted;

  // Next-state: redirect beats fetch/halt; STOPPED holds until reset.
  always_comb begin
    w_state_d      = r_state;
    w_pc_d         = r_pc;
    w_drain_addr_d = r_drain_addr;
    w_count_d      = r_count;
    w_wr_ptr_d     = r_wr_ptr;
    w_rd_ptr_d     = r_rd_ptr;
    w_halted_d     = r_halted;
    w_enq          = 1'b0;
    if (r_state != StStopped) begin
      if (io_bus.redirect) begin
        // Flush covers whatever is left after a same-cycle dequeue.
        w_pc_d     = io_bus.redirect_pc;
        w_count_d  = '0;
        w_wr_ptr_d = '0;
        w_rd_ptr_d = '0;
        if (w_req && !io_bus.imem_rvalid) begin
          w_state_d      = StDrain;
          w_drain_addr_d = w_addr;
        end else begin
          w_state_d = StFetch;
        end
      end else begin
        if (r_state == StFetch && w_done) begin
          // A bypassed word taken by decode this cycle never enters the queue.
          w_enq = ~(w_bypass & io_bus.inst_ready);
          if (is_hlt(io_bus.imem_rdata)) begin
            w_state_d = StHalt;
          end else begin
            w_pc_d = r_pc + ADDR_W'(PC_STEP);
          end
        end else if (r_state == StDrain && w_done) begin
          w_state_d = StFetch;
        end
        if (w_enq) w_wr_ptr_d = r_wr_ptr + PTR_W'(1);
        if (w_deq) w_rd_ptr_d = r_rd_ptr + PTR_W'(1);
        case ({w_enq, w_deq})
          2'b10:   w_count_d = r_count + CNT_W'(1);
          2'b01:   w_count_d = r_count - CNT_W'(1);
          default: w_count_d = r_count;
        endcase
        if (w_deq && is_hlt(w_head_data)) begin
          w_halted_d = 1'b1;
          w_state_d  = StStopped;
        end
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StFetch;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_pc         <= w_pc_d;
      r_drain_addr <= w_drain_addr_d;
      r_count      <= w_count_d;
      r_wr_ptr     <= w_wr_ptr_d;
      r_rd_ptr     <= w_rd_ptr_d;
      r_halted     <= w_halted_d;
    end
  end

  // Queue storage and last-presented head, held while the queue is empty.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_q_data[r_wr_ptr] <= io_bus.imem_rdata;
      r_q_pc[r_wr_ptr]   <= r_pc;
    end
    if (w_valid) begin
      r_hold_data <= w_head_data;
      r_hold_pc   <= w_head_pc;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit (default build, DEPTH=2).
module tb_fetch_unit;
  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(16), .INST_W(16)) bus ();

  fetch_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  logic [15:0] prog [128];
  assign bus.imem_rdata = prog[bus.imem_addr[7:1]];

  typedef struct {
    logic        rst, rvalid, ready, redir;
    logic [15:0] rpc;
    logic        chk;
    logic        e_req;
    logic [15:0] e_addr, e_pc;
    logic        e_valid;
    logic [15:0] e_ipc;
    logic        e_halted;
  } vec_t;

  vec_t vq[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(int r, int rv, int rdy, int re, int rpc, int chk, int req,
                              int addr, int pc, int val, int ipc, int hlt);
    vec_t v;
    v.rst = 1'(r);  v.rvalid = 1'(rv);  v.ready = 1'(rdy);  v.redir = 1'(re);
    v.rpc = 16'(rpc);  v.chk = 1'(chk);  v.e_req = 1'(req);
    v.e_addr = 16'(addr);  v.e_pc = 16'(pc);  v.e_valid = 1'(val);
    v.e_ipc = 16'(ipc);  v.e_halted = 1'(hlt);
    return v;
  endfunction

  task automatic add(int r, int rv, int rdy, int re, int rpc, int chk, int req, int addr,
                     int pc, int val, int ipc, int hlt);
    vq.push_back(mk(r, rv, rdy, re, rpc, chk, req, addr, pc, val, ipc, hlt));
  endtask

  task automatic add_reset();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // Drive one cycle of inputs, compare mid-cycle, then cross the clock edge.
  task automatic run_vec(input string name, input vec_t v);
    logic [15:0] e_data, a_ipc, a_data;
    rst             = v.rst;
    bus.imem_rvalid = v.rvalid;
    bus.inst_ready  = v.ready;
    bus.redirect    = v.redir;
    bus.redirect_pc = v.rpc;
    @(negedge clk);
    if (v.chk) begin
      n_vec++;
      e_data = v.e_valid ? prog[v.e_ipc[7:1]] : 16'h0;
      a_ipc  = bus.inst_valid ? bus.inst_pc : 16'h0;
      a_data = bus.inst_valid ? bus.inst_data : 16'h0;
      if (bus.imem_req !== v.e_req || bus.imem_addr !== v.e_addr || bus.pc !== v.e_pc ||
          bus.inst_valid !== v.e_valid || a_ipc !== (v.e_valid ? v.e_ipc : 16'h0) ||
          a_data !== e_data || bus.halted !== v.e_halted) begin
        n_bad++;
        $display("FAIL %s: got req=%b addr=%h pc=%h valid=%b ipc=%h data=%h halted=%b; want req=%b addr=%h pc=%h valid=%b ipc=%h data=%h halted=%b",
                 name, bus.imem_req, bus.imem_addr, bus.pc, bus.inst_valid, a_ipc, a_data,
                 bus.halted, v.e_req, v.e_addr, v.e_pc, v.e_valid,
                 v.e_valid ? v.e_ipc : 16'h0, e_data, v.e_halted);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit got;
    for (int i = 0; i < 128; i++) prog[i] = 16'h1000 | 16'(i);
    prog[0] = 16'h1000;  // ADD
    prog[1] = 16'h2000;  // SUB
    prog[2] = 16'hF000;  // HLT @0x0004
    prog[4] = 16'hF008;  // HLT @0x0008

    // Streaming ADD,SUB,HLT with zero-wait memory; STOPPED ignores redirect.
    add_reset();
    add(0, 1, 1, 0, 0,    1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0,    1, 1, 2, 2, 1, 0, 0);
    add(0, 1, 1, 0, 0,    1, 1, 4, 4, 1, 2, 0);
    add(0, 1, 1, 0, 0,    1, 0, 4, 4, 1, 4, 0);
    add(0, 1, 1, 0, 0,    1, 0, 4, 4, 0, 0, 1);
    add(0, 1, 1, 1, 'h40, 1, 0, 4, 4, 0, 0, 1);
    add(0, 1, 1, 0, 0,    1, 0, 4, 4, 0, 0, 1);
    // Back-pressure: queue fills at 2, one dequeue frees one request.
    add_reset();
    add(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 1, 2, 2, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 4, 4, 1, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0, 4, 4, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 1, 4, 4, 1, 2, 0);
    add(0, 1, 0, 0, 0, 1, 0, 4, 4, 1, 2, 0);
    // Flush on completing redirect, then DRAIN of 0x0006 while redirected to 0x0040.
    add_reset();
    add(0, 1, 0, 0, 0,    1, 1, 0,    0,    0, 0,    0);
    add(0, 1, 0, 1, 6,    1, 1, 2,    2,    1, 0,    0);
    add(0, 0, 0, 0, 0,    1, 1, 6,    6,    0, 0,    0);
    add(0, 0, 0, 1, 'h40, 1, 1, 6,    6,    0, 0,    0);
    add(0, 0, 0, 0, 0,    1, 1, 6,    'h40, 0, 0,    0);
    add(0, 1, 0, 0, 0,    1, 1, 6,    'h40, 0, 0,    0);
    add(0, 0, 1, 0, 0,    1, 1, 'h40, 'h40, 0, 0,    0);
    add(0, 1, 1, 0, 0,    1, 1, 'h40, 'h40, 0, 0,    0);
    add(0, 0, 1, 0, 0,    1, 1, 'h42, 'h42, 1, 'h40, 0);
    add(0, 0, 1, 0, 0,    1, 1, 'h42, 'h42, 0, 0,    0);
    // Speculative HLT at 0x0008 cancelled by redirect to 0x0020.
    add_reset();
    add(0, 1, 0, 1, 8,    1, 1, 0,    0,    0, 0,    0);
    add(0, 1, 0, 0, 0,    1, 1, 8,    8,    0, 0,    0);
    add(0, 1, 0, 0, 0,    1, 0, 8,    8,    1, 8,    0);
    add(0, 1, 0, 1, 'h20, 1, 0, 8,    8,    1, 8,    0);
    add(0, 1, 1, 0, 0,    1, 1, 'h20, 'h20, 0, 0,    0);
    add(0, 0, 1, 0, 0,    1, 1, 'h22, 'h22, 1, 'h20, 0);
    add(0, 0, 1, 0, 0,    1, 1, 'h22, 'h22, 0, 0,    0);
    // Reset asserted while draining.
    add_reset();
    add(0, 0, 0, 1, 'h30, 1, 1, 0, 0,    0, 0, 0);
    add(0, 0, 0, 0, 0,    1, 1, 0, 'h30, 0, 0, 0);
    add(1, 0, 0, 0, 0,    1, 0, 0, 'h30, 0, 0, 0);
    add(1, 0, 0, 0, 0,    1, 0, 0, 0,    0, 0, 0);
    add(0, 1, 1, 0, 0,    1, 1, 0, 0,    0, 0, 0);

    for (int i = 0; i < vq.size(); i++) run_vec($sformatf("vec%0d", i), vq[i]);

    // Slow memory: request held 3 cycles, completes on the 4th.
    run_vec("lat_rst0", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec("lat_rst1", mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      run_vec($sformatf("lat_wait%0d", k), mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    run_vec("lat_done", mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    bus.imem_rvalid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 4 && !got; n++) begin
      @(negedge clk);
      if (bus.inst_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_vec++;
    if (!got || bus.inst_pc !== 16'h0 || bus.inst_data !== prog[0] ||
        bus.imem_addr !== 16'h2) begin
      n_bad++;
      $display("FAIL lat_enq: got valid=%b ipc=%h data=%h addr=%h; want valid=1 ipc=0000 data=%h addr=0002",
               got, bus.inst_pc, bus.inst_data, bus.imem_addr, prog[0]);
    end
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
